key_sequencer: RTL and testbench
================================

# key_sequencer

Record/playback sequencer for the synthesizer's four note switches. It samples `keys` at a fixed tick rate into a small buffer while recording, then loops the captured sequence back out on `playback_keys`. It reports its current `mode` to the GUI renderer, which draws live or played-back keys. It sits between the board switches/pushbutton and the GUI, in the recorder slot of the top level.

## Interface
- `DEPTH`, 64: number of sample slots; power of two, at least 2.
- `TICK_DIV`, 2_500_000: clock cycles per sample tick (50 ms at 50 MHz).
- `clock`  in  1  system clock (CLOCK_50).
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  active-low pushbutton (KEY[1]); hardware-debounced, so no debounce logic.
- `keys`  in  4  live note switches (SW[3:0]); asynchronous to `clock`.
- `mode`  out  2  00 IDLE, 01 RECORD, 10 PLAYBACK; 11 is never driven.
- `playback_keys`  out  4  replayed key state; 0 outside PLAYBACK.
- `rec_len`  out  log2(DEPTH)+1  number of valid samples captured.

## Operation
- **Input synchronisers**
  - `go` passes through two flops (s1, s2), then one delay flop (s3).
  - `go_press` = s3 & ~s2, a single-cycle pulse on each press.
  - `keys` passes through two flops. Only the synchronised value is ever stored.
- **State machine.** `mode` is the state register.
  - IDLE, on `go_press` -> RECORD. Same edge: wr_ptr=0, rec_len=0, tick counter=0.
  - RECORD, on `go_press` -> PLAYBACK. Same edge: rd_ptr=0, tick counter=0.
  - RECORD, on the tick write to slot DEPTH-1 -> PLAYBACK automatically, same edge.
  - PLAYBACK, on `go_press` -> IDLE. Same edge: `playback_keys` cleared to 0.
  - `go_press` coincident with the final-slot tick in RECORD: exactly one transition to PLAYBACK. The press is consumed.
- **Tick counter**
  - Counts 0..TICK_DIV-1. `tick` is high when count == TICK_DIV-1, then the counter wraps to 0.
  - Cleared on every state transition.
  - Free-running in IDLE, where it is unused.
- **RECORD, each tick**
  - mem[wr_ptr] <= synced keys.
  - wr_ptr <= wr_ptr+1.
  - rec_len <= wr_ptr+1.
- **PLAYBACK, each tick**
  - If rec_len == 0: `playback_keys` stays 0.
  - Else: `playback_keys` <= mem[rd_ptr]. rd_ptr <= 0 if rd_ptr == rec_len-1, else rd_ptr+1. The sequence loops indefinitely.
  - Between ticks, `playback_keys` holds its value.
- **Retention and memory**
  - rec_len and memory contents are retained in IDLE.
  - A new RECORD overwrites from slot 0.
  - Memory is a register array or inferred RAM with combinational read at rd_ptr. Memory is not reset.

## Timing
- Reset (async, `reset`=0): outputs take these values immediately and hold while reset is low.
  - `mode`=00, `playback_keys`=0, `rec_len`=0.
  - All pointers, the tick counter and s1/s2/s3 are cleared. s1–s3 reset to 1, i.e. button released.
- Reset asserted mid-RECORD or mid-PLAYBACK aborts to IDLE with rec_len=0. Nothing is preserved.
- Press latency: `go` falls before rising edge N. Then s2=0 at edge N+1, `go_press` is high during cycle N+1, and `mode` changes at edge N+2.
- Holding `go` low produces exactly one `go_press`. The next press requires a release of at least 2 cycles.
- The first RECORD sample is written TICK_DIV cycles after entry; sample k is written at entry + (k+1)·TICK_DIV.
- The first PLAYBACK output appears TICK_DIV cycles after entry. `playback_keys` is 0 until then.
- `keys` sampling latency is 2 cycles (synchroniser). The stored value is the synced value at the tick edge.
- Maximum recording is DEPTH·TICK_DIV cycles (3.2 s at defaults).

## Test plan
Bench settings: DEPTH=8, TICK_DIV=4, 50 MHz clock.
- Reset then idle: hold `reset`=0 for 3 cycles, release, run 20 cycles -> `mode`=00, `playback_keys`=0, `rec_len`=0 throughout.
- Basic loop:
  - Press `go`, then present `keys`=1,2,4,8, each held for 4 cycles and aligned to ticks. Press `go` after the 4th sample -> `rec_len`=4, `mode`=10.
  - Then `playback_keys` = 1,2,4,8,1,2,… changing every 4 cycles. First value appears 4 cycles after `mode` becomes 10.
- Auto-stop: enter RECORD and hold `keys`=4'hA for 40 cycles -> `mode` becomes 10 at the 8th tick, `rec_len`=8, and playback outputs A on every tick.
- Empty recording: press `go` twice within 3 cycles of RECORD entry (no tick) -> `mode`=10, `rec_len`=0, `playback_keys` stays 0 for 40 cycles.
- Press handling: hold `go` low for 50 cycles from IDLE -> exactly one transition (00->01), occurring at the 3rd edge after `go` falls. Press `go` in PLAYBACK -> `mode`=00 and `playback_keys`=0 on the same edge; `rec_len` retained.
- Async reset: assert `reset` mid-PLAYBACK, between clock edges -> `mode`=00, `playback_keys`=0, `rec_len`=0 before the next edge. Release, press `go` -> `mode`=01 and recording restarts at slot 0.

Source files
------------

// File: rtl/key_sequencer.sv
// key_sequencer: records the four note switches into a tick-paced buffer and
// loops the captured sequence back out for the GUI.
module key_sequencer #(
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 2_500_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     go,
    input  logic [3:0]               keys,
    output logic [1:0]               mode,
    output logic [3:0]               playback_keys,
    output logic [$clog2(DEPTH):0]   rec_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, RECORD = 2'b01, PLAYBACK = 2'b10} state_t;

    state_t        state_q, state_d;
    logic          go_s1_q, go_s2_q, go_s3_q;
    logic [3:0]    keys_s1_q, keys_s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   rec_len_q, rec_len_d;
    logic [3:0]    pk_q, pk_d;
    logic [3:0]    mem_q [DEPTH];
    logic          go_press, tick, mem_we;

    assign go_press      = go_s3_q & ~go_s2_q;
    assign tick          = cnt_q == CW'(TICK_DIV - 1);
    assign mode          = state_q;
    assign playback_keys = pk_q;
    assign rec_len       = rec_len_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rec_len_d = rec_len_q;
        pk_d      = pk_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: if (go_press) begin
                state_d   = RECORD;
                wr_ptr_d  = '0;
                rec_len_d = '0;
            end
            RECORD: begin
                if (tick) begin
                    mem_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    rec_len_d = {1'b0, wr_ptr_q} + 1'b1;
                end
                // a press landing on the final-slot tick still yields a single transition
                if (go_press || (tick && wr_ptr_q == AW'(DEPTH - 1))) begin
                    state_d  = PLAYBACK;
                    rd_ptr_d = '0;
                end
            end
            PLAYBACK: if (go_press) begin
                state_d = IDLE;
                pk_d    = '0;
            end else if (tick && rec_len_q != '0) begin
                pk_d     = mem_q[rd_ptr_q];
                rd_ptr_d = ({1'b0, rd_ptr_q} == rec_len_q - 1'b1) ? '0 : rd_ptr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            go_s1_q   <= 1'b1;
            go_s2_q   <= 1'b1;
            go_s3_q   <= 1'b1;
            keys_s1_q <= '0;
            keys_s2_q <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rec_len_q <= '0;
            pk_q      <= '0;
        end else begin
            state_q   <= state_d;
            go_s1_q   <= go;
            go_s2_q   <= go_s1_q;
            go_s3_q   <= go_s2_q;
            keys_s1_q <= keys;
            keys_s2_q <= keys_s1_q;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rec_len_q <= rec_len_d;
            pk_q      <= pk_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[wr_ptr_q] <= keys_s2_q;
    end
endmodule

// File: tb/tb_key_sequencer.sv
// tb_key_sequencer: directed record/playback scenarios with hand-computed expectations.
module tb_key_sequencer;
    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       go    = 1'b1;
    logic [3:0] keys  = 4'h0;
    logic [1:0] mode;
    logic [3:0] playback_keys;
    logic [3:0] rec_len;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    always #10 clock = ~clock;

    key_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clock(clock), .reset(reset), .go(go), .keys(keys),
        .mode(mode), .playback_keys(playback_keys), .rec_len(rec_len)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] m, input logic [3:0] pk, input logic [3:0] rl);
        check(tag, {6'd0, mode, playback_keys, rec_len}, {6'd0, m, pk, rl});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press();
        go = 1'b0;
        step(1);
        go = 1'b1;
        step(2);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_out("in_reset", 2'd0, 4'h0, 4'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_out("idle", 2'd0, 4'h0, 4'd0);
        end

        keys = vals[0];
        press();
        for (int k = 0; k < 4; k++) begin
            check_out("rec", 2'd1, 4'h0, 4'(k));
            keys = vals[k];
            step(4);
        end
        check_out("rec4", 2'd1, 4'h0, 4'd4);
        press();
        check_out("pb_entry", 2'd2, 4'h0, 4'd4);
        step(3);
        check_out("pb_wait", 2'd2, 4'h0, 4'd4);
        step(1);
        check_out("pb_first", 2'd2, vals[0], 4'd4);
        for (int i = 1; i < 6; i++) begin
            step(2);
            check_out("pb_hold", 2'd2, vals[(i - 1) % 4], 4'd4);
            step(2);
            check_out("pb_loop", 2'd2, vals[i % 4], 4'd4);
        end
        press();
        check_out("pb_stop", 2'd0, 4'h0, 4'd4);

        keys = 4'hA;
        press();
        check_out("as_entry", 2'd1, 4'h0, 4'd0);
        step(31);
        check_out("as_pre", 2'd1, 4'h0, 4'd7);
        step(1);
        check_out("as_stop", 2'd2, 4'h0, 4'd8);
        step(3);
        check_out("as_wait", 2'd2, 4'h0, 4'd8);
        step(1);
        check_out("as_first", 2'd2, 4'hA, 4'd8);
        for (int i = 0; i < 10; i++) begin
            step(4);
            check_out("as_loop", 2'd2, 4'hA, 4'd8);
        end
        press();
        check_out("as_idle", 2'd0, 4'h0, 4'd8);

        press();
        check_out("empty_rec", 2'd1, 4'h0, 4'd0);
        press();
        check_out("empty_pb", 2'd2, 4'h0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step(4);
            check_out("empty_loop", 2'd2, 4'h0, 4'd0);
        end
        press();
        check_out("empty_idle", 2'd0, 4'h0, 4'd0);

        keys = 4'h5;
        go   = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            step(1);
            check("hold_mode", 16'(mode), (j < 3) ? 16'd0 : (j < 35) ? 16'd1 : 16'd2);
        end
        go = 1'b1;
        step(3);
        check_out("hold_pb", 2'd2, 4'h5, 4'd8);
        press();
        check_out("hold_idle", 2'd0, 4'h0, 4'd8);

        keys = 4'h3;
        press();
        step(8);
        check_out("ar_rec", 2'd1, 4'h0, 4'd2);
        press();
        step(4);
        check_out("ar_pb", 2'd2, 4'h3, 4'd2);
        #5 reset = 1'b0;
        #1 check_out("ar_async", 2'd0, 4'h0, 4'd0);
        step(1);
        check_out("ar_held", 2'd0, 4'h0, 4'd0);
        reset = 1'b1;
        keys  = 4'h6;
        press();
        check_out("ar_restart", 2'd1, 4'h0, 4'd0);
        step(4);
        check_out("ar_slot0", 2'd1, 4'h0, 4'd1);
        press();
        check_out("ar_pb2", 2'd2, 4'h0, 4'd1);
        step(4);
        check_out("ar_replay", 2'd2, 4'h6, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
